lsu: RTL and testbench

Load/store unit for the single-issue RISC-V core. It sits directly downstream of the main decoder and consumes its memory-side controls: `MemWrite`, the two-bit `AccessMode` size code and the one-bit `DataExtendMode` flag. It runs one byte/half/word access on a valid/ack data-memory bus, splitting any misaligned access into two aligned word beats. It returns the load result aligned and sign- or zero-extended, ready for the register-file write mux.

---
 rtl/lsu.sv | 112 +++++++++++
 tb/tb_lsu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: byte/half/word load-store unit on a valid/ack word bus; misaligned accesses become two aligned beats.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            MemWrite,
  input  logic [1:0]      AccessMode,
  input  logic            DataExtendMode,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;
  state_t state, state_n;
  logic accept, split_in, final_ack;
  logic [2:0] size_b;
  logic [3:0] mask;
  logic [7:0] be8;
  logic [63:0] wd64;
  logic we_q, ext_q, split_q;
  logic [1:0] mode_q, off_q;
  logic [3:0] hi_be;
  logic [31:0] hi_wd, lo, lo_n, hi_n, r, ld;
  function automatic logic [31:0] lanes(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign accept = req_valid && req_ready;
  assign size_b = AccessMode == 2'b00 ? 3'd1 : AccessMode == 2'b01 ? 3'd2 : 3'd4;
  assign mask = AccessMode == 2'b00 ? 4'b0001 : AccessMode == 2'b01 ? 4'b0011 : 4'b1111;
  assign split_in = ({1'b0, addr[1:0]} + size_b) > 3'd4;
  assign be8 = {4'b0, mask} << addr[1:0];
  assign wd64 = {32'b0, wdata} << {addr[1:0], 3'b000};
  assign final_ack = mem_ack && (state == ACC1 || (state == ACC0 && !split_q));
  // The beat being acked is merged in directly so rdata can register on the final ack edge.
  assign lo_n = state == ACC0 ? mem_rdata : lo;
  assign hi_n = state == ACC1 ? mem_rdata : 32'b0;
  assign r = 32'({hi_n, lo_n} >> {off_q, 3'b000});
  assign ld = mode_q == 2'b00 ? {{24{ext_q & r[7]}}, r[7:0]} :
              mode_q == 2'b01 ? {{16{ext_q & r[15]}}, r[15:0]} : r;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = ACC0;
      ACC0: if (mem_ack) state_n = split_q ? ACC1 : DONE;
      ACC1: if (mem_ack) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q <= 1'b0;
      ext_q <= 1'b0;
      split_q <= 1'b0;
      mode_q <= 2'b0;
      off_q <= 2'b0;
      hi_be <= 4'b0;
      hi_wd <= 32'b0;
      lo <= 32'b0;
      rdata <= 32'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= 32'b0;
      mem_be <= 4'b0;
      mem_wdata <= 32'b0;
    end else begin
      if (accept) begin
        we_q <= MemWrite;
        ext_q <= DataExtendMode;
        split_q <= split_in;
        mode_q <= AccessMode;
        off_q <= addr[1:0];
        hi_be <= be8[7:4];
        hi_wd <= wd64[63:32] & lanes(be8[7:4]);
        mem_req <= 1'b1;
        mem_we <= MemWrite;
        mem_addr <= {addr[31:2], 2'b00};
        mem_be <= MemWrite ? be8[3:0] : 4'hf;
        mem_wdata <= MemWrite ? wd64[31:0] & lanes(be8[3:0]) : 32'b0;
      end
      if (state == ACC0 && mem_ack) begin
        lo <= mem_rdata;
        if (split_q) begin
          mem_addr <= mem_addr + 32'd4;
          mem_be <= we_q ? hi_be : 4'hf;
          mem_wdata <= we_q ? hi_wd : 32'b0;
        end
      end
      if (final_ack) begin
        mem_req <= 1'b0;
        rdata <= we_q ? 32'b0 : ld;
      end
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and random load/store checks of lsu against a byte-addressed memory model.
module tb_lsu;
  logic clk = 0, reset = 1, req_valid = 0, MemWrite = 0, DataExtendMode = 0, mem_ack = 0;
  logic [1:0] AccessMode = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic req_ready, busy, done, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int n_cmp = 0, n_err = 0;
  logic [7:0] mem [logic [31:0]];

  lsu dut (.clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemWrite(MemWrite), .AccessMode(AccessMode), .DataExtendMode(DataExtendMode),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rb(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic logic [31:0] rw(input logic [31:0] a);
    return {rb(a + 32'd3), rb(a + 32'd2), rb(a + 32'd1), rb(a)};
  endfunction

  task automatic ww(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic run_op(input logic we, input logic [1:0] md, input logic ex,
                        input logic [31:0] a, input logic [31:0] wd, input int waits, input string tag);
    int size, nb, k, cyc, beats, w;
    logic [31:0] w0, b, ld, exp_rd, saddr, swd;
    logic [3:0] ebe [2];
    logic [31:0] ewd [2];
    logic [3:0] sbe;
    logic first;
    size = md == 2'b00 ? 1 : md == 2'b01 ? 2 : 4;
    w0 = {a[31:2], 2'b00};
    nb = 1;
    ld = 0;
    for (int j = 0; j < 2; j++) begin ebe[j] = 0; ewd[j] = 0; end
    for (int i = 0; i < size; i++) begin
      b = a + 32'(i);
      k = int'((b - w0) >> 2);
      if (k == 1) nb = 2;
      ebe[k][b[1:0]] = 1'b1;
      ewd[k][8*b[1:0] +: 8] = wd[8*i +: 8];
      ld[8*i +: 8] = rb(b);
    end
    if (ex && size < 4) for (int j = 8 * size; j < 32; j++) ld[j] = ld[8*size-1];
    if (!we) for (int j = 0; j < 2; j++) begin ebe[j] = 4'hf; ewd[j] = 0; end
    exp_rd = we ? 32'b0 : ld;
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1);
    req_valid = 1; MemWrite = we; AccessMode = md; DataExtendMode = ex; addr = a; wdata = wd;
    @(negedge clk);
    req_valid = 0; MemWrite = 1'($urandom); AccessMode = 2'($urandom);
    DataExtendMode = 1'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 1; beats = 0; w = 0; first = 1;
    saddr = 0; sbe = 0; swd = 0;
    while (!done && cyc < 100) begin
      if (beats < nb) chk({tag, ".req"}, mem_req, 1);
      chk({tag, ".busy"}, busy, 1);
      if (mem_req) begin
        if (first && beats < 2) begin
          chk($sformatf("%s.addr%0d", tag, beats), mem_addr, w0 + 32'(4 * beats));
          chk($sformatf("%s.be%0d", tag, beats), mem_be, ebe[beats]);
          chk($sformatf("%s.wd%0d", tag, beats), mem_wdata, ewd[beats]);
          chk($sformatf("%s.we%0d", tag, beats), mem_we, we);
          saddr = mem_addr; sbe = mem_be; swd = mem_wdata; first = 0;
        end else if (!first) begin
          chk({tag, ".hold_addr"}, mem_addr, saddr);
          chk({tag, ".hold_be"}, mem_be, sbe);
          chk({tag, ".hold_wd"}, mem_wdata, swd);
        end
        if (w == waits) begin
          mem_ack = 1; mem_rdata = rw(mem_addr);
          if (mem_we) ww(mem_addr, mem_wdata, mem_be);
          beats++; w = 0; first = 1;
        end else begin
          mem_ack = 0; mem_rdata = $urandom; w++;
        end
      end else mem_ack = 0;
      @(negedge clk);
      cyc++;
    end
    mem_ack = 0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".latency"}, cyc, nb * (waits + 1) + 1);
    chk({tag, ".beats"}, beats, nb);
    chk({tag, ".rdata"}, rdata, exp_rd);
    chk({tag, ".req_off"}, mem_req, 0);
    chk({tag, ".ready_busy"}, {busy, req_ready}, 2'b10);
    @(negedge clk);
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".ready_after"}, req_ready, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst.req", mem_req, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.be", mem_be, 0);
    chk("rst.wd", mem_wdata, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.done_busy", {done, busy}, 0);
    chk("rst.ready", req_ready, 1);
    reset = 0;
    ww(32'h100, 32'h80AABBCC, 4'hf);
    run_op(0, 2'b00, 1, 32'h103, 0, 0, "lb");
    ww(32'h100, 32'h1234ABCD, 4'hf);
    run_op(0, 2'b01, 0, 32'h102, 0, 0, "lhu");
    ww(32'h100, 32'h44332211, 4'hf);
    ww(32'h104, 32'h88776655, 4'hf);
    run_op(0, 2'b10, 0, 32'h101, 0, 0, "lw_mis");
    run_op(1, 2'b01, 0, 32'h103, 32'h0000BEEF, 0, "sh_mis");
    run_op(0, 2'b10, 0, 32'h100, 0, 1, "lw_after_sh0");
    run_op(0, 2'b10, 0, 32'h104, 0, 0, "lw_after_sh1");
    run_op(0, 2'b10, 1, 32'hFFFFFFFE, 0, 2, "lw_wrap");
    @(negedge clk);
    req_valid = 1; MemWrite = 0; AccessMode = 2'b10; DataExtendMode = 0; addr = 32'h1FE;
    @(negedge clk);
    req_valid = 0;
    chk("rmid.req0", mem_req, 1);
    mem_ack = 1; mem_rdata = rw(mem_addr);
    @(negedge clk);
    mem_ack = 0;
    chk("rmid.req1", mem_req, 1);
    chk("rmid.addr1", mem_addr, 32'h200);
    @(negedge clk);
    reset = 1;
    #1;
    chk("rmid.req_async", mem_req, 0);
    chk("rmid.ready_async", {req_ready, busy, done}, 3'b100);
    @(negedge clk);
    reset = 0; mem_ack = 1; mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 0;
    chk("rmid.stray_done", done, 0);
    chk("rmid.stray_req", mem_req, 0);
    chk("rmid.stray_ready", {req_ready, busy}, 2'b10);
    @(negedge clk);
    chk("rmid.done_late", done, 0);
    run_op(1, 2'b10, 0, 32'h1FE, 32'hCAFEF00D, 0, "sw_post_rst");
    run_op(0, 2'b01, 1, 32'h1FF, 0, 1, "lh_post_rst");
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                      : 32'h200 + 32'($urandom_range(0, 31));
      run_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
